// File: rtl/uart_reg_access_arbiter_if.sv
// AXI4-Lite slave channels plus the UART core register bus, bundled for the arbiter.
interface uart_reg_access_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4
);
    logic [ADDR_W-1:0] s_awaddr;
    logic              s_awvalid;
    logic              s_awready;
    logic [DATA_W-1:0] s_wdata;
    logic [3:0]        s_wstrb;
    logic              s_wvalid;
    logic              s_wready;
    logic [1:0]        s_bresp;
    logic              s_bvalid;
    logic              s_bready;
    logic [ADDR_W-1:0] s_araddr;
    logic              s_arvalid;
    logic              s_arready;
    logic [DATA_W-1:0] s_rdata;
    logic [1:0]        s_rresp;
    logic              s_rvalid;
    logic              s_rready;
    logic [1:0]        u_address;
    logic              u_write_enable;
    logic [DATA_W-1:0] u_write_data;
    logic              u_read_enable;
    logic [DATA_W-1:0] u_read_data;

    // slave = the arbiter: AXI slave upstream, register-bus master towards the UART.
    modport slave (
        input  s_awaddr, s_awvalid, s_wdata, s_wstrb, s_wvalid, s_bready,
        input  s_araddr, s_arvalid, s_rready, u_read_data,
        output s_awready, s_wready, s_bresp, s_bvalid, s_arready,
        output s_rdata, s_rresp, s_rvalid,
        output u_address, u_write_enable, u_write_data, u_read_enable
    );

    modport master (
        output s_awaddr, s_awvalid, s_wdata, s_wstrb, s_wvalid, s_bready,
        output s_araddr, s_arvalid, s_rready, u_read_data,
        input  s_awready, s_wready, s_bresp, s_bvalid, s_arready,
        input  s_rdata, s_rresp, s_rvalid,
        input  u_address, u_write_enable, u_write_data, u_read_enable
    );
endinterface

// File: rtl/uart_reg_access_arbiter.sv
// Serialises AXI4-Lite writes and reads onto the UART core's single-port register bus,
// alternating grants on contention and generating one-cycle enable strobes.
module uart_reg_access_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4,
    parameter int RD_LAT = 1
) (
    input logic                       clk,
    input logic                       rst,
    uart_reg_access_arbiter_if.slave  bus
);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {IDLE, WR_ACC, WR_RESP, RD_ACC, RD_WAIT, RD_RESP} state_e;
    typedef enum logic {GNT_WRITE, GNT_READ} grant_e;

    state_e            state_q, state_d;
    grant_e            last_grant_q, last_grant_d;
    logic              aw_held_q, aw_held_d, w_held_q, w_held_d, ar_held_q, ar_held_d;
    logic [ADDR_W-1:0] awaddr_q, awaddr_d, araddr_q, araddr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [3:0]        wstrb_q, wstrb_d;
    logic              awready_q, wready_q, arready_q;
    logic [1:0]        u_address_q, u_address_d;
    logic [DATA_W-1:0] u_wdata_q, u_wdata_d;
    logic              u_we_q, u_we_d, u_re_q, u_re_d;
    logic              bvalid_q, bvalid_d, rvalid_q, rvalid_d;
    logic [1:0]        bresp_q, bresp_d, rresp_q, rresp_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              rd_err_q, rd_err_d;
    logic [1:0]        cnt_q, cnt_d;
    logic              aw_hs, w_hs, ar_hs, b_hs, r_hs;
    logic              wr_pend, rd_pend, wr_ok, grant_wr;

    always_comb begin
        // NOTE: every signal gets a default before the case, so no path can infer a latch.
        aw_hs = bus.s_awvalid & awready_q;
        w_hs  = bus.s_wvalid & wready_q;
        ar_hs = bus.s_arvalid & arready_q;
        b_hs  = bvalid_q & bus.s_bready;
        r_hs  = rvalid_q & bus.s_rready;

        // A handshake this cycle is visible to arbitration, so a grant costs no extra cycle.
        awaddr_d  = aw_hs ? bus.s_awaddr : awaddr_q;
        wdata_d   = w_hs ? bus.s_wdata : wdata_q;
        wstrb_d   = w_hs ? bus.s_wstrb : wstrb_q;
        araddr_d  = ar_hs ? bus.s_araddr : araddr_q;
        aw_held_d = aw_held_q | aw_hs;
        w_held_d  = w_held_q | w_hs;
        ar_held_d = ar_held_q | ar_hs;

        state_d      = state_q;
        last_grant_d = last_grant_q;
        u_address_d  = u_address_q;
        u_wdata_d    = u_wdata_q;
        u_we_d       = 1'b0;
        u_re_d       = 1'b0;
        bvalid_d     = bvalid_q;
        bresp_d      = bresp_q;
        rvalid_d     = rvalid_q;
        rresp_d      = rresp_q;
        rdata_d      = rdata_q;
        rd_err_d     = rd_err_q;
        cnt_d        = cnt_q;
        grant_wr     = 1'b0;

        wr_pend = aw_held_d & w_held_d;
        rd_pend = ar_held_d;
        // Register 3 is RX data; partial or misaligned writes are refused as well.
        wr_ok   = (awaddr_d[3:2] != 2'b11) && (awaddr_d[1:0] == 2'b00) && (wstrb_d == 4'hF);

        unique case (state_q)
            IDLE: begin
                // last_grant only moves on contention, so back-to-back pairs swap order.
                if (wr_pend && rd_pend) begin
                    grant_wr     = (last_grant_q == GNT_READ);
                    last_grant_d = grant_wr ? GNT_WRITE : GNT_READ;
                end else begin
                    grant_wr = wr_pend;
                end
                if (grant_wr) begin
                    state_d     = WR_ACC;
                    u_address_d = awaddr_d[3:2];
                    u_wdata_d   = wdata_d;
                    u_we_d      = wr_ok;
                end else if (rd_pend) begin
                    state_d     = RD_ACC;
                    u_address_d = araddr_d[3:2];
                    u_re_d      = (araddr_d[1:0] == 2'b00);
                    rd_err_d    = (araddr_d[1:0] != 2'b00);
                    cnt_d       = 2'd1;
                end
            end
            WR_ACC: begin
                bvalid_d = 1'b1;
                bresp_d  = wr_ok ? RESP_OKAY : RESP_SLVERR;
                state_d  = WR_RESP;
            end
            WR_RESP: begin
                if (b_hs) begin
                    bvalid_d  = 1'b0;
                    aw_held_d = 1'b0;
                    w_held_d  = 1'b0;
                    state_d   = IDLE;
                end
            end
            RD_ACC: state_d = RD_WAIT;
            RD_WAIT: begin
                if (cnt_q == 2'(RD_LAT)) begin
                    rdata_d  = rd_err_q ? '0 : bus.u_read_data;
                    rresp_d  = rd_err_q ? RESP_SLVERR : RESP_OKAY;
                    rvalid_d = 1'b1;
                    state_d  = RD_RESP;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            RD_RESP: begin
                if (r_hs) begin
                    rvalid_d  = 1'b0;
                    ar_held_d = 1'b0;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers sample pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= GNT_READ;
            aw_held_q    <= 1'b0;
            w_held_q     <= 1'b0;
            ar_held_q    <= 1'b0;
            awaddr_q     <= '0;
            araddr_q     <= '0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
            awready_q    <= 1'b0;
            wready_q     <= 1'b0;
            arready_q    <= 1'b0;
            u_address_q  <= '0;
            u_wdata_q    <= '0;
            u_we_q       <= 1'b0;
            u_re_q       <= 1'b0;
            bvalid_q     <= 1'b0;
            bresp_q      <= '0;
            rvalid_q     <= 1'b0;
            rresp_q      <= '0;
            rdata_q      <= '0;
            rd_err_q     <= 1'b0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            aw_held_q    <= aw_held_d;
            w_held_q     <= w_held_d;
            ar_held_q    <= ar_held_d;
            awaddr_q     <= awaddr_d;
            araddr_q     <= araddr_d;
            wdata_q      <= wdata_d;
            wstrb_q      <= wstrb_d;
            awready_q    <= ~aw_held_d;
            wready_q     <= ~w_held_d;
            arready_q    <= ~ar_held_d;
            u_address_q  <= u_address_d;
            u_wdata_q    <= u_wdata_d;
            u_we_q       <= u_we_d;
            u_re_q       <= u_re_d;
            bvalid_q     <= bvalid_d;
            bresp_q      <= bresp_d;
            rvalid_q     <= rvalid_d;
            rresp_q      <= rresp_d;
            rdata_q      <= rdata_d;
            rd_err_q     <= rd_err_d;
            cnt_q        <= cnt_d;
        end
    end

    assign bus.s_awready      = awready_q;
    assign bus.s_wready       = wready_q;
    assign bus.s_arready      = arready_q;
    assign bus.s_bvalid       = bvalid_q;
    assign bus.s_bresp        = bresp_q;
    assign bus.s_rvalid       = rvalid_q;
    assign bus.s_rresp        = rresp_q;
    assign bus.s_rdata        = rdata_q;
    assign bus.u_address      = u_address_q;
    assign bus.u_write_data   = u_wdata_q;
    assign bus.u_write_enable = u_we_q;
    assign bus.u_read_enable  = u_re_q;
endmodule
